cache_bram_v3: RTL and testbench
================================

CACHE_BRAM_V3 -- requirements
Module: cache_bram_v3

Interface
REQ-001 SHALL have parameter DATA_W, default 529, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter RD_MODE, default READ_FIRST, same-port read-during-write mode (READ_FIRST or WRITE_FIRST).
REQ-004 SHALL have parameter OUT_REG, default 0, extra output pipeline stage when 1.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, zero the whole array after reset when 1.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 ready  output  1  high when the array accepts accesses.
REQ-009 data_en / inst_en  input  1 each  port access enable.
REQ-010 data_we / inst_we  input  1 each  port write enable, qualified by *_en.
REQ-011 data_addr / inst_addr  input  ADDR_W each  port address.
REQ-012 data_in / inst_in  input  DATA_W each  port write data.
REQ-013 data_out / inst_out  output  DATA_W each  port read data.
REQ-014 data_valid / inst_valid  output  1 each  read data valid strobe.
REQ-015 collision  output  1  one-cycle pulse on same-address dual write.

Function
REQ-016 Access on port p SHALL occur only when p_en && ready at a rising edge; otherwise array and p_out unchanged.
REQ-017 Read latency SHALL be 1 + OUT_REG cycles from accepted access to p_valid high with p_out.
REQ-018 p_valid SHALL pulse for exactly one cycle per accepted access, including write accesses.
REQ-019 READ_FIRST: a write access SHALL return the old word; WRITE_FIRST: it SHALL return p_in.
REQ-020 Both ports writing the same address in one cycle: data port SHALL win, inst write discarded, collision high next cycle.
REQ-021 One port writing, other reading the same address in one cycle: reader SHALL return the old word.
REQ-022 p_out SHALL hold its last value when no access completes.
REQ-023 Control FSM SHALL have states CLEAR, READY (package enum).
REQ-024 CLEAR: ADDR_W-bit counter SHALL write 0 to address 0..DEPTH-1, one per cycle; port accesses ignored, ready low.
REQ-025 CLEAR -> READY SHALL occur on the cycle after address DEPTH-1 is written; counter wrap-around SHALL NOT restart clearing.
REQ-026 With CLEAR_ON_RESET=0 the FSM SHALL enter READY on the first edge after reset release; array contents undefined.
REQ-027 READY SHALL be absorbing until rst_n is asserted.

Reset
REQ-028 On rst_n low: ready=0, data_valid=inst_valid=0, collision=0, data_out=inst_out=0, pipeline registers 0, counter 0, state CLEAR.
REQ-029 rst_n asserted mid-clear SHALL restart clearing from address 0 after release.
REQ-030 rst_n asserted with reads in flight SHALL drop them; no valid pulse after release.
REQ-031 Array contents SHALL NOT be reset asynchronously; only the clear sequence zeroes them.

Structure
REQ-032 Package cache_bram_pkg SHALL hold the rd_mode_e enum (READ_FIRST, WRITE_FIRST) and the state_e enum (CLEAR, READY).
REQ-033 Clear FSM plus counter SHALL be sub-module cache_bram_clear_ctrl (outputs clr_we, clr_addr, ready).
REQ-034 Array SHALL be a single true-dual-port inferable memory; clear writes SHALL use the data port.

Verification
REQ-035 Reset release, CLEAR_ON_RESET=1, ADDR_W=4: ready rises exactly 17 cycles after release; reads at 0..15 return 0.
REQ-036 Write 0x1A5 at addr 3 via data, read addr 3 via inst next cycle: inst_out=0x1A5 with inst_valid after 1 cycle (OUT_REG=0), or 2 (OUT_REG=1).
REQ-037 Same-addr dual write, data=0xAA, inst=0x55, addr 7: collision pulses once; later read returns 0xAA.
REQ-038 Addr 5 holds 0x11, write 0x22 to addr 5 on data port: data_out=0x11 (READ_FIRST) or 0x22 (WRITE_FIRST).
REQ-039 rst_n pulsed low at clear address 8: outputs 0 immediately; clearing restarts at 0, ready after full DEPTH+1 cycles.
REQ-040 Accesses with ready low: no valid pulses, array unchanged; data_en low in READY: data_out holds prior value.

Source files
------------

// File: rtl/cache_bram_v3_pkg.sv
// Shared types for the dual-port cache BRAM: read-during-write mode and
// the clear/ready control states.
package cache_bram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rd_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/cache_bram_v3_if.sv
// Port bundle for the dual-port cache BRAM (data port + instruction port).
//
// Handshake: a port access is accepted on a rising edge where p_en && ready.
// There is no other backpressure. Every accepted access (read or write)
// produces exactly one p_valid strobe 1 + OUT_REG cycles later, with p_out
// carrying the returned word; p_out holds its value between strobes.
interface cache_bram_v3_if #(
    parameter int DATA_W = 529,
    parameter int ADDR_W = 10
) ();
    logic              ready;
    logic              data_en;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              inst_en;
    logic              inst_we;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_in;
    logic [DATA_W-1:0] inst_out;
    logic              inst_valid;
    logic              collision;

    modport slave (
        input  data_en, data_we, data_addr, data_in,
        input  inst_en, inst_we, inst_addr, inst_in,
        output ready, data_out, data_valid, inst_out, inst_valid, collision
    );

    modport master (
        output data_en, data_we, data_addr, data_in,
        output inst_en, inst_we, inst_addr, inst_in,
        input  ready, data_out, data_valid, inst_out, inst_valid, collision
    );
endinterface

// File: rtl/cache_bram_v3_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once writing zero, then
// raises ready and stays there until the next reset.
module cache_bram_clear_ctrl
    import cache_bram_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready,
    output state_e            state
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;

    // Next state: done_q marks that the last address was written, so the
    // counter wrapping back to zero never starts a second pass.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                if (CLEAR_ON_RESET == 0 || done_q) begin
                    state_d = READY;
                end else begin
                    clr_we = 1'b1;
                    cnt_d  = cnt_q + ADDR_W'(1);
                    if (cnt_q == '1) begin
                        done_d = 1'b1;
                    end
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // State, counter and done flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign clr_addr = cnt_q;
    assign ready    = (state_q == READY);
    assign state    = state_q;

endmodule

// File: rtl/cache_bram_v3.sv
// True-dual-port cache BRAM with a data port and an instruction port,
// optional output register, selectable read-during-write behaviour and a
// zero-fill pass after reset that borrows the data port.
module cache_bram_v3
    import cache_bram_pkg::*;
#(
    parameter int       DATA_W         = 529,
    parameter int       ADDR_W         = 10,
    parameter rd_mode_e RD_MODE        = READ_FIRST,
    parameter int       OUT_REG        = 0,
    parameter int       CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    cache_bram_v3_if.slave  bus,
    output state_e          dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              data_acc, inst_acc, data_wr, inst_wr_req, inst_wr, coll;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din;
    logic [DATA_W-1:0] data_rd_word, inst_rd_word, data_ret, inst_ret;

    logic [DATA_W-1:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic [DATA_W-1:0] inst_s1_q, inst_s1_d, inst_s2_q, inst_s2_d;
    logic              data_s1_vld_q, data_s1_vld_d, data_s2_vld_q, data_s2_vld_d;
    logic              inst_s1_vld_q, inst_s1_vld_d, inst_s2_vld_q, inst_s2_vld_d;
    logic              collision_q, collision_d;

    cache_bram_clear_ctrl #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready),
        .state    (dbg_state)
    );

    // Port arbitration, clear muxing onto the data port, returned words and
    // next values of the output pipeline.
    always_comb begin
        data_acc     = bus.data_en & ready;
        inst_acc     = bus.inst_en & ready;
        data_wr      = data_acc & bus.data_we;
        inst_wr_req  = inst_acc & bus.inst_we;
        coll         = data_wr & inst_wr_req & (bus.data_addr == bus.inst_addr);
        inst_wr      = inst_wr_req & ~coll;

        a_we         = clr_we | data_wr;
        a_addr       = clr_we ? clr_addr : bus.data_addr;
        a_din        = clr_we ? '0 : bus.data_in;

        data_rd_word = mem[bus.data_addr];
        inst_rd_word = mem[bus.inst_addr];
        data_ret     = (RD_MODE == WRITE_FIRST && data_wr)     ? bus.data_in : data_rd_word;
        inst_ret     = (RD_MODE == WRITE_FIRST && inst_wr_req) ? bus.inst_in : inst_rd_word;

        data_s1_vld_d = data_acc;
        data_s1_d     = data_acc ? data_ret : data_s1_q;
        inst_s1_vld_d = inst_acc;
        inst_s1_d     = inst_acc ? inst_ret : inst_s1_q;
        data_s2_vld_d = data_s1_vld_q;
        data_s2_d     = data_s1_vld_q ? data_s1_q : data_s2_q;
        inst_s2_vld_d = inst_s1_vld_q;
        inst_s2_d     = inst_s1_vld_q ? inst_s1_q : inst_s2_q;
        collision_d   = coll;
    end

    // Array writes; contents survive reset and are only zeroed by clearing.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_din;
        end
        if (inst_wr) begin
            mem[bus.inst_addr] <= bus.inst_in;
        end
    end

    // Output pipeline and collision pulse; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s1_q     <= '0;
            data_s1_vld_q <= 1'b0;
            data_s2_q     <= '0;
            data_s2_vld_q <= 1'b0;
            inst_s1_q     <= '0;
            inst_s1_vld_q <= 1'b0;
            inst_s2_q     <= '0;
            inst_s2_vld_q <= 1'b0;
            collision_q   <= 1'b0;
        end else begin
            data_s1_q     <= data_s1_d;
            data_s1_vld_q <= data_s1_vld_d;
            data_s2_q     <= data_s2_d;
            data_s2_vld_q <= data_s2_vld_d;
            inst_s1_q     <= inst_s1_d;
            inst_s1_vld_q <= inst_s1_vld_d;
            inst_s2_q     <= inst_s2_d;
            inst_s2_vld_q <= inst_s2_vld_d;
            collision_q   <= collision_d;
        end
    end

    assign bus.ready      = ready;
    assign bus.data_out   = (OUT_REG != 0) ? data_s2_q     : data_s1_q;
    assign bus.data_valid = (OUT_REG != 0) ? data_s2_vld_q : data_s1_vld_q;
    assign bus.inst_out   = (OUT_REG != 0) ? inst_s2_q     : inst_s1_q;
    assign bus.inst_valid = (OUT_REG != 0) ? inst_s2_vld_q : inst_s1_vld_q;
    assign bus.collision  = collision_q;

endmodule

// File: tb/tb_cache_bram_v3.sv
// Bench for cache_bram_v3: two instances share one stimulus stream,
// dut0 = READ_FIRST / OUT_REG=0, dut1 = WRITE_FIRST / OUT_REG=1.
module tb_cache_bram_v3;
    import cache_bram_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          data_en = 0, data_we = 0, inst_en = 0, inst_we = 0;
    logic [AW-1:0] data_addr = 0, inst_addr = 0;
    logic [DW-1:0] data_in = 0, inst_in = 0;

    cache_bram_v3_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    cache_bram_v3_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    assign if0.data_en = data_en;   assign if1.data_en = data_en;
    assign if0.data_we = data_we;   assign if1.data_we = data_we;
    assign if0.data_addr = data_addr; assign if1.data_addr = data_addr;
    assign if0.data_in = data_in;   assign if1.data_in = data_in;
    assign if0.inst_en = inst_en;   assign if1.inst_en = inst_en;
    assign if0.inst_we = inst_we;   assign if1.inst_we = inst_we;
    assign if0.inst_addr = inst_addr; assign if1.inst_addr = inst_addr;
    assign if0.inst_in = inst_in;   assign if1.inst_in = inst_in;

    state_e dbg0, dbg1;

    cache_bram_v3 #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(READ_FIRST),
                    .OUT_REG(0), .CLEAR_ON_RESET(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .dbg_state(dbg0));

    cache_bram_v3 #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(WRITE_FIRST),
                    .OUT_REG(1), .CLEAR_ON_RESET(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .dbg_state(dbg1));

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t",
                     name, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each accepted access becomes a queue entry due at a given edge number
    // (edge of acceptance + output register depth); index = dut*2 + port.
    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } item_t;

    item_t         pq [4][$];
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_out [4];
    logic          exp_vld [4];
    logic          exp_coll = 1'b0;
    int            since = 0;
    int            edge_n = 0;

    initial begin
        for (int k = 0; k < 4; k++) begin
            exp_out[k] = '0;
            exp_vld[k] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                since    = 0;
                exp_coll = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    pq[k].delete();
                    exp_out[k] = '0;
                    exp_vld[k] = 1'b0;
                end
            end else begin
                logic          rdy, d_acc, i_acc, d_wr, i_wr;
                logic [DW-1:0] old_d, old_i;
                item_t         it;
                rdy   = (since >= DEPTH + 1);
                d_acc = rdy && data_en;
                i_acc = rdy && inst_en;
                d_wr  = d_acc && data_we;
                i_wr  = i_acc && inst_we;
                old_d = mem_m[data_addr];
                old_i = mem_m[inst_addr];
                exp_coll = d_wr && i_wr && (data_addr == inst_addr);
                if (i_wr && !exp_coll) mem_m[inst_addr] = inst_in;
                if (d_wr) mem_m[data_addr] = data_in;
                for (int d = 0; d < 2; d++) begin
                    if (d_acc) begin
                        it.due = edge_n + d;
                        it.val = (d == 1 && d_wr) ? data_in : old_d;
                        pq[d*2].push_back(it);
                    end
                    if (i_acc) begin
                        it.due = edge_n + d;
                        it.val = (d == 1 && i_wr) ? inst_in : old_i;
                        pq[d*2+1].push_back(it);
                    end
                end
                if (since <= DEPTH) begin
                    since++;
                    if (since == DEPTH + 1) begin
                        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    exp_vld[k] = 1'b0;
                    if (pq[k].size() > 0 && pq[k][0].due == edge_n) begin
                        exp_vld[k] = 1'b1;
                        exp_out[k] = pq[k][0].val;
                        void'(pq[k].pop_front());
                    end
                end
                edge_n++;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic rdy_m;
                rdy_m = (since >= DEPTH + 1);
                check("ready",      0, if0.ready,      rdy_m);
                check("ready",      1, if1.ready,      rdy_m);
                check("state",      0, dbg0,           rdy_m ? READY : CLEAR);
                check("state",      1, dbg1,           rdy_m ? READY : CLEAR);
                check("data_valid", 0, if0.data_valid, exp_vld[0]);
                check("data_out",   0, if0.data_out,   exp_out[0]);
                check("inst_valid", 0, if0.inst_valid, exp_vld[1]);
                check("inst_out",   0, if0.inst_out,   exp_out[1]);
                check("data_valid", 1, if1.data_valid, exp_vld[2]);
                check("data_out",   1, if1.data_out,   exp_out[2]);
                check("inst_valid", 1, if1.inst_valid, exp_vld[3]);
                check("inst_out",   1, if1.inst_out,   exp_out[3]);
                check("collision",  0, if0.collision,  exp_coll);
                check("collision",  1, if1.collision,  exp_coll);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic set_in(input logic den, input logic dwe, input logic [AW-1:0] da,
                          input logic [DW-1:0] dd, input logic ien, input logic iwe,
                          input logic [AW-1:0] ia, input logic [DW-1:0] idd);
        data_en = den; data_we = dwe; data_addr = da; data_in = dd;
        inst_en = ien; inst_we = iwe; inst_addr = ia; inst_in = idd;
    endtask

    task automatic idle();
        set_in(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic rand_in(input int amax);
        data_en   = ($urandom_range(0, 3) != 0);
        data_we   = 1'($urandom_range(0, 1));
        data_addr = AW'($urandom_range(0, amax));
        data_in   = DW'($urandom);
        inst_en   = ($urandom_range(0, 3) != 0);
        inst_we   = 1'($urandom_range(0, 1));
        inst_addr = AW'($urandom_range(0, amax));
        inst_in   = DW'($urandom);
    endtask

    // Counts edges from release until ready is seen, with random traffic
    // that must be ignored while clearing.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            rand_in(DEPTH - 1);
            tick();
            n++;
        end while (!if0.ready && n < 100);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_ready"}, 0, if0.ready,      0);
        check({name, "_dout"},  0, if0.data_out,   0);
        check({name, "_iout"},  0, if0.inst_out,   0);
        check({name, "_dout"},  1, if1.data_out,   0);
        check({name, "_iout"},  1, if1.inst_out,   0);
        check({name, "_dvld"},  1, if1.data_valid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) tick();
        check_zero_outputs("rst");

        // Release and time the clear pass.
        rst_n = 1'b1;
        wait_ready(n);
        check("ready_latency", 0, n, DEPTH + 1);
        check("ready_latency", 1, if1.ready, 1);

        // Every word reads back as zero after clearing.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 0, AW'(i), '0, 1, 0, AW'(DEPTH - 1 - i), '0);
            tick();
            check("clr_rd_vld", 0, if0.data_valid, 1);
            check("clr_rd_val", 0, if0.data_out, 0);
            check("clr_rd_val", 0, if0.inst_out, 0);
        end

        // Data-port write then instruction-port read of the same word.
        set_in(1, 1, 4'd3, 16'h01A5, 0, 0, '0, '0);
        tick();
        set_in(0, 0, '0, '0, 1, 0, 4'd3, '0);
        tick();
        check("xport_vld", 0, if0.inst_valid, 1);
        check("xport_val", 0, if0.inst_out, 16'h01A5);
        check("xport_vld", 1, if1.inst_valid, 0);
        idle();
        tick();
        check("xport_vld", 1, if1.inst_valid, 1);
        check("xport_val", 1, if1.inst_out, 16'h01A5);

        // Same-address dual write: data port wins, one collision pulse.
        set_in(1, 1, 4'd7, 16'h00AA, 1, 1, 4'd7, 16'h0055);
        tick();
        check("coll_pulse", 0, if0.collision, 1);
        check("coll_pulse", 1, if1.collision, 1);
        idle();
        tick();
        check("coll_clear", 0, if0.collision, 0);
        set_in(1, 0, 4'd7, '0, 1, 0, 4'd7, '0);
        tick();
        check("coll_winner", 0, if0.data_out, 16'h00AA);
        check("coll_winner", 0, if0.inst_out, 16'h00AA);
        idle();
        tick();

        // Same-port read-during-write.
        set_in(1, 1, 4'd5, 16'h0011, 0, 0, '0, '0);
        tick();
        set_in(1, 1, 4'd5, 16'h0022, 0, 0, '0, '0);
        tick();
        check("rdw_old", 0, if0.data_out, 16'h0011);
        check("rdw_new", 1, if1.data_out, 16'h0011);
        idle();
        tick();
        check("rdw_new", 1, if1.data_out, 16'h0022);
        check("hold", 0, if0.data_out, 16'h0011);
        check("hold_vld", 0, if0.data_valid, 0);

        // Reset with reads in flight: outputs drop at once, nothing later.
        set_in(1, 0, 4'd5, '0, 1, 0, 4'd7, '0);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_inflight");
        repeat (2) tick();
        check("rst_inflight_vld", 1, if1.data_valid, 0);

        // Reset in the middle of clearing (address 8 pending).
        rst_n = 1'b1;
        repeat (8) begin
            rand_in(DEPTH - 1);
            tick();
        end
        check("midclr_notready", 0, if0.ready, 0);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_midclr");
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        check("ready_latency2", 0, n, DEPTH + 1);

        // Random traffic over a narrow address range to provoke collisions.
        for (int c = 0; c < 400; c++) begin
            rand_in(7);
            tick();
        end
        idle();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
